edge_point_extract: RTL and testbench

EDGE_POINT_EXTRACT -- requirements
Module: edge_point_extract

---
 rtl/edge_point_extract_pkg.sv | 20 ++
 rtl/edge_point_extract_fifo.sv | 54 +++++
 rtl/edge_point_extract.sv | 144 ++++++++++++++
 tb/tb_edge_point_extract.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_point_extract_pkg.sv
// Shared lane-detection types: coordinate width,
// point bundle and edge-extract FSM states.
package edge_point_extract_pkg;

  localparam int CW = 12;

  typedef logic [CW-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    SCAN       = 2'd1,
    DRAIN      = 2'd2
  } state_e;

endpackage

// File: rtl/edge_point_extract_fifo.sv
// Show-ahead point buffer between edge extraction
// and the Hough voter; full writes are refused.
module point_fifo
  import edge_point_extract_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en_i,
  input  point_t wr_data_i,
  input  logic   rd_en_i,
  output point_t rd_data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  point_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr;
  logic          do_rd;

  assign full_o    = (cnt_q == FULL_CNT);
  assign empty_o   = (cnt_q == '0);
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/edge_point_extract.sv
// Scans binary eroded pixels, buffers ROI edge points
// and hands them to the Hough voter per frame.
module edge_point_extract
  import edge_point_extract_pkg::*;
#(
  parameter coord_t H_DISP     = 12'd480,
  parameter coord_t V_DISP     = 12'd272,
  parameter coord_t ROI_Y_TOP  = 12'd136,
  parameter coord_t ROI_X_L    = 12'd0,
  parameter coord_t ROI_X_R    = 12'd479,
  parameter int     FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        erode_de,
  input  logic        erode_hsync,
  input  logic        erode_vsync,
  input  logic [7:0]  erode_data,
  output logic        pt_valid,
  input  logic        pt_ready,
  output coord_t      pt_x,
  output coord_t      pt_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] drop_cnt
);

  state_e      state_q;
  logic        vs_q, de_q;
  coord_t      x_q, x_d, y_q, y_d;
  logic        wr_q;
  point_t      wr_pt_q;
  logic [15:0] drop_q, drop_d;
  logic        fs_q, fd_q;

  logic   vs_rise, de_fall;
  logic   in_x, in_y, hit, drop;
  logic   fifo_full, fifo_empty;
  coord_t dx, dy;
  point_t rd_pt;
  logic   unused_hsync;

  assign unused_hsync = erode_hsync;
  assign vs_rise = erode_vsync & ~vs_q;
  assign de_fall = de_q & ~erode_de;

  // wrap-around subtraction turns each bound pair into one compare
  assign dx   = x_q - ROI_X_L;
  assign dy   = y_q - ROI_Y_TOP;
  assign in_x = (dx <= (ROI_X_R - ROI_X_L)) && (x_q < H_DISP);
  assign in_y = dy < (V_DISP - ROI_Y_TOP);

  assign hit = (state_q == SCAN) & ~vs_rise & erode_de
             & (|erode_data) & in_x & in_y;

  assign drop = wr_q & fifo_full;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vs_rise) begin
      x_d = '0;
      y_d = '0;
    end else begin
      if (erode_de && x_q != H_DISP) x_d = x_q + 1'b1;
      if (de_fall) begin
        x_d = '0;
        if (y_q != V_DISP) y_d = y_q + 1'b1;
      end
    end
  end

  always_comb begin
    drop_d = drop_q;
    if (vs_rise) drop_d = '0;
    else if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      wr_q    <= 1'b0;
      wr_pt_q <= '0;
      drop_q  <= '0;
    end else begin
      vs_q    <= erode_vsync;
      de_q    <= erode_de;
      x_q     <= x_d;
      y_q     <= y_d;
      wr_q    <= hit;
      wr_pt_q <= '{x: x_q, y: y_q};
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FRAME;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      fs_q <= vs_rise;
      fd_q <= 1'b0;
      if (vs_rise) begin
        state_q <= SCAN;
      end else begin
        unique case (state_q)
          SCAN:
            if (y_q == V_DISP) state_q <= DRAIN;
          DRAIN:
            if (fifo_empty && !wr_q) begin
              state_q <= WAIT_FRAME;
              fd_q    <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

  point_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_q),
    .wr_data_i (wr_pt_q),
    .rd_en_i   (pt_ready),
    .rd_data_o (rd_pt),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign pt_valid    = ~fifo_empty;
  assign pt_x        = pt_valid ? rd_pt.x : '0;
  assign pt_y        = pt_valid ? rd_pt.y : '0;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_edge_point_extract.sv
// Scoreboard bench: frames of short lines with chosen
// hot pixels, reference points queued, monitor pops.
module tb_edge_point_extract;

  localparam int H     = 480;
  localparam int V     = 272;
  localparam int YT    = 136;
  localparam int XL    = 0;
  localparam int XR    = 479;
  localparam int DEPTH = 16;

  typedef struct {
    int x;
    int y;
  } pt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        pt_ready = 1'b0;
  logic        pt_valid;
  logic [11:0] pt_x, pt_y;
  logic        frame_start, frame_done;
  logic [15:0] drop_cnt;

  pt_t sb[$];
  pt_t hot[$];
  logic [7:0] linebuf [512] = '{default: 8'h00};

  int n_chk = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int fd_cnt = 0;
  int fd_base = 0;
  int cur_y = 0;
  int frame_pts = 0;
  int exp_drop = 0;
  int rmode = 0;
  bit model_stall = 1'b0;
  bit rdy_hold = 1'b0;

  always #5 clk = ~clk;

  edge_point_extract #(
    .H_DISP     (12'd480),
    .V_DISP     (12'd272),
    .ROI_Y_TOP  (12'd136),
    .ROI_X_L    (12'd0),
    .ROI_X_R    (12'd479),
    .FIFO_DEPTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .erode_de    (de),
    .erode_hsync (hs),
    .erode_vsync (vs),
    .erode_data  (data),
    .pt_valid    (pt_valid),
    .pt_ready    (pt_ready),
    .pt_x        (pt_x),
    .pt_y        (pt_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (rmode)
      1:       pt_ready = ~pt_ready;
      2:       pt_ready = 1'($urandom_range(0, 1));
      default: pt_ready = rdy_hold;
    endcase
  end

  logic        prev_stall = 1'b0;
  logic [11:0] prev_x = '0;
  logic [11:0] prev_y = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_start) fs_cnt++;
      if (frame_done) fd_cnt++;
      if (prev_stall) begin
        check("hold_valid", 32'(pt_valid), 1);
        check("hold_x", 32'(pt_x), 32'(prev_x));
        check("hold_y", 32'(pt_y), 32'(prev_y));
      end
      if (pt_valid && pt_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_point: got (%0d,%0d) required none",
                   pt_x, pt_y);
        end else begin
          pt_t e;
          e = sb.pop_front();
          check("pt_x", 32'(pt_x), e.x);
          check("pt_y", 32'(pt_y), e.y);
        end
      end
      prev_stall = pt_valid && !pt_ready;
      prev_x = pt_x;
      prev_y = pt_y;
    end
  end

  // Reference: a lit pixel inside the region becomes a point; while the
  // consumer is held off for the whole frame only DEPTH points fit.
  task automatic model_pixel(input int x);
    if (linebuf[x] != 0 && x >= XL && x <= XR && x < H &&
        cur_y >= YT && cur_y < V) begin
      if (model_stall && frame_pts >= DEPTH) begin
        exp_drop++;
      end else begin
        sb.push_back('{x, cur_y});
        frame_pts++;
      end
    end
  endtask

  task automatic send_rows(input int n);
    for (int r = 0; r < n; r++) begin
      int len;
      int gap;
      len = 1;
      foreach (hot[k]) begin
        if (hot[k].y == cur_y) begin
          linebuf[hot[k].x] = 8'hFF;
          if (hot[k].x + 1 > len) len = hot[k].x + 1;
        end
      end
      for (int i = 0; i < len; i++) begin
        de = 1'b1;
        data = linebuf[i];
        model_pixel(i);
        tick();
      end
      de = 1'b0;
      data = 8'h00;
      gap = $urandom_range(1, 2);
      repeat (gap) tick();
      for (int i = 0; i < len; i++) linebuf[i] = 8'h00;
      cur_y++;
    end
  endtask

  task automatic start_frame();
    int f0;
    f0 = fs_cnt;
    de = 1'b0;
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    tick();
    tick();
    check("frame_start", fs_cnt, f0 + 1);
    check("drop_clear", 32'(drop_cnt), 0);
    cur_y = 0;
    frame_pts = 0;
    exp_drop = 0;
    fd_base = fd_cnt;
  endtask

  task automatic end_frame();
    int t;
    t = 0;
    while (fd_cnt == fd_base && t < 500) begin
      tick();
      t++;
    end
    check("frame_done", fd_cnt, fd_base + 1);
    tick();
    tick();
    check("single_done", fd_cnt, fd_base + 1);
    check("sb_empty", sb.size(), 0);
    check("drop_cnt", 32'(drop_cnt), exp_drop);
  endtask

  task automatic run_frame();
    start_frame();
    send_rows(V);
    end_frame();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(pt_valid), 0);
    check("rst_x", 32'(pt_x), 0);
    check("rst_y", 32'(pt_y), 0);
    check("rst_fstart", 32'(frame_start), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_drop", 32'(drop_cnt), 0);
    rst_n = 1'b1;
    rdy_hold = 1'b1;
    tick();
    tick();

    // single point inside the region
    hot = '{'{10, 200}};
    run_frame();

    // point above the region top
    hot = '{'{10, 100}};
    run_frame();

    // region and saturation boundaries
    hot = '{'{0, 136}, '{479, 137}, '{5, 135}, '{485, 200},
            '{3, 271}, '{2, 0}, '{480, 150}};
    run_frame();

    // overflow with consumer stalled
    rdy_hold = 1'b0;
    tick();
    model_stall = 1'b1;
    hot.delete();
    for (int i = 0; i < 20; i++) hot.push_back('{i, 200});
    start_frame();
    send_rows(V);
    tick();
    tick();
    check("stall_valid", 32'(pt_valid), 1);
    check("stall_drop", 32'(drop_cnt), exp_drop);
    model_stall = 1'b0;
    rdy_hold = 1'b1;
    end_frame();

    // ready toggling through a burst
    rmode = 1;
    hot.delete();
    for (int i = 30; i < 50; i++) hot.push_back('{i, 210});
    run_frame();
    rmode = 0;
    tick();

    // vsync restart mid-frame
    hot = '{'{5, 140}};
    start_frame();
    send_rows(150);
    tick();
    tick();
    check("abort_no_done", fd_cnt, fd_base);
    hot = '{'{7, 140}, '{8, 140}};
    start_frame();
    send_rows(V);
    end_frame();

    // reset with buffered points
    rdy_hold = 1'b0;
    tick();
    model_stall = 1'b1;
    hot.delete();
    for (int i = 0; i < 5; i++) hot.push_back('{i, 200});
    start_frame();
    send_rows(201);
    tick();
    tick();
    tick();
    check("pre_rst_valid", 32'(pt_valid), 1);
    check("pre_rst_x", 32'(pt_x), sb[0].x);
    check("pre_rst_y", 32'(pt_y), sb[0].y);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 32'(pt_valid), 0);
    check("rst_mid_x", 32'(pt_x), 0);
    sb.delete();
    model_stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    rdy_hold = 1'b1;
    repeat (4) tick();
    check("post_rst_empty", 32'(pt_valid), 0);
    check("post_rst_drop", 32'(drop_cnt), 0);
    hot = '{'{12, 250}};
    run_frame();

    // random frames with random back-pressure
    rmode = 2;
    for (int f = 0; f < 4; f++) begin
      int n;
      hot.delete();
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++)
        hot.push_back('{$urandom_range(0, 47), $urandom_range(136, 271)});
      for (int k = 0; k < 3; k++)
        hot.push_back('{$urandom_range(0, 47), $urandom_range(0, 135)});
      run_frame();
    end
    rmode = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
